// File: rtl/tone_note_detector_if.sv
// Signal bundle for tone_note_detector: the raw tone input plus the note, period and LED outputs.
interface tone_note_detector_if;
  logic        TONE_IN;
  logic [2:0]  NOTE;
  logic        NOTE_VALID;
  logic        NOTE_STROBE;
  logic [16:0] PERIOD;
  logic [2:0]  RGB_LED;

  modport master (output TONE_IN, input NOTE, NOTE_VALID, NOTE_STROBE, PERIOD, RGB_LED);
  modport slave  (input TONE_IN, output NOTE, NOTE_VALID, NOTE_STROBE, PERIOD, RGB_LED);
endinterface

// File: rtl/tone_note_detector.sv
// Measures the TONE_IN period in CLK_IN cycles and locks onto one of eight notes (523..1046 Hz).
// Optional macro TONE_DUTY_CHECK_EN: also measure high time and reject periods that are not near 50% duty.
//   state | meaning
//   IDLE  | no tone seen; wait for the first rising edge
//   ARMED | first edge seen; the period in progress is the first complete one
//   TRACK | every rising edge closes a period that is classified
module tone_note_detector #(
  parameter int CLK_HZ     = 12000000,
  parameter int TIMEOUT    = 100000,
  parameter int STABLE_CNT = 3,
  parameter int TOL_SHIFT  = 6
) (
  input logic                 CLK_IN,
  input logic                 RST_N,
  tone_note_detector_if.slave bus
);

  localparam int NP [8] = '{
    2 * (CLK_HZ / 523 + 1),
    2 * (CLK_HZ / 587 + 1),
    2 * (CLK_HZ / 659 + 1),
    2 * (CLK_HZ / 698 + 1),
    2 * (CLK_HZ / 783 + 1),
    2 * (CLK_HZ / 880 + 1),
    2 * (CLK_HZ / 987 + 1),
    2 * (CLK_HZ / 1046 + 1)
  };
  localparam logic [16:0] TMO    = 17'(TIMEOUT);
  localparam logic [2:0]  STABLE = 3'(STABLE_CNT);

  typedef enum logic [1:0] {IDLE, ARMED, TRACK} state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q, sync3_q;
  logic [16:0] cnt_q, cnt_d;
  logic [16:0] period_q, period_d;
  logic [2:0]  note_q, note_d;
  logic        valid_q, valid_d;
  logic        strobe_q, strobe_d;
  logic [2:0]  run_q, run_d;
  logic [2:0]  bad_q, bad_d;
  logic [2:0]  prev_q, prev_d;
  logic        rise, tmo_hit;
  logic [2:0]  cand_idx;
  logic        cand_ok;
  logic        duty_ok;

  assign rise    = sync2_q & ~sync3_q;
  assign tmo_hit = (cnt_q == TMO);

  function automatic logic in_window(input logic [16:0] p, input int np);
    int diff;
    diff = (int'(p) >= np) ? int'(p) - np : np - int'(p);
    return diff <= (np >> TOL_SHIFT);
  endfunction

`ifdef TONE_DUTY_CHECK_EN
  logic [16:0] hcnt_q, hcnt_d;
  int          twice_h, duty_err;

  // hcnt_q counts synced-high cycles since the last rise, including the rise cycle itself
  always_comb begin
    hcnt_d = hcnt_q;
    if (rise)
      hcnt_d = 17'd1;
    else if (sync2_q && hcnt_q != TMO)
      hcnt_d = hcnt_q + 17'd1;
  end

  always_comb begin
    twice_h  = 2 * int'(hcnt_q);
    duty_err = (twice_h >= int'(cnt_q)) ? twice_h - int'(cnt_q) : int'(cnt_q) - twice_h;
    duty_ok  = (duty_err <= (int'(cnt_q) >> 3));
  end

  always_ff @(posedge CLK_IN) begin
    if (!RST_N) hcnt_q <= '0;
    else        hcnt_q <= hcnt_d;
  end
`else
  assign duty_ok = 1'b1;
`endif

  // cnt_q equals the period length in the cycle where the closing rise is seen
  always_comb begin
    cand_idx = 3'd0;
    cand_ok  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (in_window(cnt_q, NP[i])) begin
        cand_idx = 3'(i);
        cand_ok  = 1'b1;
      end
    end
    if (!duty_ok) cand_ok = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    note_d   = note_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;
    run_d    = run_q;
    bad_d    = bad_q;
    prev_d   = prev_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d = ARMED;
          cnt_d   = 17'd1;
        end
      end
      ARMED, TRACK: begin
        if (rise) begin
          state_d  = TRACK;
          cnt_d    = 17'd1;
          period_d = cnt_q;
          prev_d   = cand_idx;
          if (cand_ok) begin
            bad_d = '0;
            if (run_q != 3'd0 && prev_q == cand_idx)
              run_d = (run_q >= STABLE) ? run_q : run_q + 3'd1;
            else
              run_d = 3'd1;
            if (run_d == STABLE && (!valid_q || note_q != cand_idx)) begin
              note_d   = cand_idx;
              valid_d  = 1'b1;
              strobe_d = 1'b1;
            end
          end else begin
            run_d = '0;
            bad_d = (bad_q >= STABLE) ? bad_q : bad_q + 3'd1;
            if (bad_d == STABLE) valid_d = 1'b0;
          end
        end else if (tmo_hit) begin
          state_d  = IDLE;
          cnt_d    = '0;
          valid_d  = 1'b0;
          run_d    = '0;
          bad_d    = '0;
          period_d = TMO;
        end else begin
          cnt_d = cnt_q + 17'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_IN) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      note_q   <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      run_q    <= '0;
      bad_q    <= '0;
      prev_q   <= '0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= bus.TONE_IN;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      note_q   <= note_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
      run_q    <= run_d;
      bad_q    <= bad_d;
      prev_q   <= prev_d;
    end
  end

  assign bus.NOTE        = note_q;
  assign bus.NOTE_VALID  = valid_q;
  assign bus.NOTE_STROBE = strobe_q;
  assign bus.PERIOD      = period_q;
  assign bus.RGB_LED     = valid_q ? note_q : 3'd0;

endmodule

// File: tb/tb_tone_note_detector.sv
// Self-checking bench for tone_note_detector, run with a scaled-down CLK_HZ/TIMEOUT to keep periods short.
module tb_tone_note_detector;
  localparam int CLK_HZ    = 187500;
  localparam int TIMEOUT   = 1500;
  localparam int STABLE    = 3;
  localparam int TOL_SHIFT = 6;
  localparam int FREQ [8]  = '{523, 587, 659, 698, 783, 880, 987, 1046};

  logic CLK_IN = 1'b0;
  logic RST_N  = 1'b0;
  tone_note_detector_if bus();

  tone_note_detector #(.CLK_HZ(CLK_HZ), .TIMEOUT(TIMEOUT), .STABLE_CNT(STABLE), .TOL_SHIFT(TOL_SHIFT))
    dut (.CLK_IN(CLK_IN), .RST_N(RST_N), .bus(bus));

  always #5 CLK_IN = ~CLK_IN;

  int n_vec = 0, n_err = 0;
  int cyc = 0, strobe_seen = 0, last_rise_cyc = 0;

  always @(posedge CLK_IN) cyc++;
  always @(posedge CLK_IN) begin
    #1;
    if (bus.NOTE_STROBE === 1'b1) strobe_seen++;
  end

  // period-level reference: note table from the frequency list, decisions from the last STABLE classifications
  int np_tab [8];
  int m_note = 0, m_period = 0, m_strobes = 0, m_len = 0, m_high = 0;
  bit m_valid = 1'b0, m_edge = 1'b0;
  int hist [$];

  function automatic int classify(input int p, input int h);
    int r, d;
    r = -1;
    for (int i = 0; i < 8; i++) begin
      d = p - np_tab[i];
      if (d < 0) d = -d;
      if (d <= (np_tab[i] >> TOL_SHIFT)) r = i;
    end
`ifdef TONE_DUTY_CHECK_EN
    d = 2 * h - p;
    if (d < 0) d = -d;
    if (d > (p >> 3)) r = -1;
`else
    if (h < 0) r = -1;
`endif
    return r;
  endfunction

  task automatic model_rise();
    int c;
    bit same;
    if (m_edge) begin
      m_period = m_len;
      c = classify(m_len, m_high);
      hist.push_back(c);
      if (hist.size() > STABLE) void'(hist.pop_front());
      if (hist.size() == STABLE) begin
        same = 1'b1;
        foreach (hist[i]) if (hist[i] != c) same = 1'b0;
        if (same && c >= 0 && (!m_valid || c != m_note)) begin
          m_note = c;
          m_valid = 1'b1;
          m_strobes++;
        end
        if (same && c < 0) m_valid = 1'b0;
      end
    end
    m_edge = 1'b1;
  endtask

  task automatic model_clear(input int period);
    hist.delete();
    m_edge = 1'b0;
    m_valid = 1'b0;
    m_period = period;
  endtask

  function automatic logic [23:0] exp_status();
    logic [2:0] rgb;
    rgb = m_valid ? 3'(m_note) : 3'd0;
    return {m_valid, 3'(m_note), 17'(m_period), rgb};
  endfunction

  function automatic logic [23:0] act_status();
    return {bus.NOTE_VALID, bus.NOTE, bus.PERIOD, bus.RGB_LED};
  endfunction

  task automatic tone_period(input int h, input int l);
    model_rise();
    m_len = h + l;
    m_high = h;
    last_rise_cyc = cyc;
    bus.TONE_IN = 1'b1;
    repeat (h) @(negedge CLK_IN);
    bus.TONE_IN = 1'b0;
    repeat (l) @(negedge CLK_IN);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    bus.TONE_IN = 1'b0;
    repeat (3) @(negedge CLK_IN);
    n_vec++;
    if (act_status() !== 24'd0 || bus.NOTE_STROBE !== 1'b0) begin
      n_err++;
      $display("FAIL reset: status got %h strobe %b, want 0", act_status(), bus.NOTE_STROBE);
    end
    RST_N = 1'b1;
    @(negedge CLK_IN);
    n_vec++;
    if (act_status() !== 24'd0) begin
      n_err++;
      $display("FAIL reset_release: status got %h want 0", act_status());
    end
  endtask

  task automatic test_lock_523();
    for (int i = 0; i < 3; i++) begin
      tone_period(359, 359);
      n_vec++;
      if (act_status() !== exp_status()) begin
        n_err++;
        $display("FAIL lock523 p%0d: status got %h want %h", i, act_status(), exp_status());
      end
    end
    model_rise();
    m_len = 718;
    m_high = 359;
    bus.TONE_IN = 1'b1;
    repeat (2) @(negedge CLK_IN);
    n_vec++;
    if (bus.NOTE_VALID !== 1'b0) begin
      n_err++;
      $display("FAIL lock523 early: valid got %b want 0", bus.NOTE_VALID);
    end
    @(negedge CLK_IN);
    n_vec++;
    if (act_status() !== exp_status() || act_status() !== {1'b1, 3'd0, 17'd718, 3'd0} || bus.NOTE_STROBE !== 1'b1) begin
      n_err++;
      $display("FAIL lock523 edge: status got %h strobe %b want %h strobe 1", act_status(), bus.NOTE_STROBE, exp_status());
    end
    @(negedge CLK_IN);
    n_vec++;
    if (bus.NOTE_STROBE !== 1'b0) begin
      n_err++;
      $display("FAIL lock523 strobe_width: strobe got %b want 0", bus.NOTE_STROBE);
    end
    repeat (355) @(negedge CLK_IN);
    bus.TONE_IN = 1'b0;
    repeat (359) @(negedge CLK_IN);
    n_vec++;
    if (strobe_seen !== m_strobes || m_strobes != 1) begin
      n_err++;
      $display("FAIL lock523 strobes: got %0d want %0d (model %0d)", strobe_seen, 1, m_strobes);
    end
  endtask

  task automatic test_switch();
    for (int i = 0; i < 7; i++) begin
      if (i < 3) tone_period(214, 214);
      else       tone_period(180, 180);
      n_vec++;
      if (act_status() !== exp_status()) begin
        n_err++;
        $display("FAIL switch p%0d: status got %h want %h", i, act_status(), exp_status());
      end
      if (i == 4 || i == 5) begin
        n_vec++;
        if (bus.NOTE !== 3'd5 || bus.NOTE_VALID !== 1'b1) begin
          n_err++;
          $display("FAIL switch hold p%0d: note %0d valid %b want 5 1", i, bus.NOTE, bus.NOTE_VALID);
        end
      end
    end
    n_vec++;
    if (bus.NOTE !== 3'd7 || bus.NOTE_VALID !== 1'b1 || strobe_seen !== m_strobes) begin
      n_err++;
      $display("FAIL switch final: note %0d valid %b strobes %0d want 7 1 %0d", bus.NOTE, bus.NOTE_VALID, strobe_seen, m_strobes);
    end
  endtask

  task automatic test_tolerance();
    int pv [4];
    bit want [4];
    pv = '{729, 730, 707, 706};
    want = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        tone_period(pv[k] / 2, pv[k] - pv[k] / 2);
        n_vec++;
        if (act_status() !== exp_status()) begin
          n_err++;
          $display("FAIL tol P=%0d p%0d: status got %h want %h", pv[k], i, act_status(), exp_status());
        end
      end
      n_vec++;
      if (bus.NOTE_VALID !== want[k] || strobe_seen !== m_strobes) begin
        n_err++;
        $display("FAIL tol P=%0d: valid %b strobes %0d want %b %0d", pv[k], bus.NOTE_VALID, strobe_seen, want[k], m_strobes);
      end
    end
  endtask

  task automatic test_out_of_band();
    int s0;
    s0 = strobe_seen;
    for (int i = 0; i < 5; i++) begin
      tone_period(313, 313);
      n_vec++;
      if (act_status() !== exp_status()) begin
        n_err++;
        $display("FAIL oob p%0d: status got %h want %h", i, act_status(), exp_status());
      end
    end
    n_vec++;
    if (bus.NOTE_VALID !== 1'b0 || bus.PERIOD !== 17'd626 || strobe_seen != s0) begin
      n_err++;
      $display("FAIL oob final: valid %b period %0d strobes %0d want 0 626 %0d", bus.NOTE_VALID, bus.PERIOD, strobe_seen - s0, 0);
    end
  endtask

  task automatic test_timeout();
    int target;
    for (int i = 0; i < 4; i++) tone_period(285, 285);
    n_vec++;
    if (act_status() !== exp_status() || bus.NOTE !== 3'd2 || bus.NOTE_VALID !== 1'b1) begin
      n_err++;
      $display("FAIL timeout lock: status got %h want %h", act_status(), exp_status());
    end
    target = last_rise_cyc + TIMEOUT + 2;
    while (cyc < target) @(negedge CLK_IN);
    n_vec++;
    if (bus.NOTE_VALID !== 1'b1) begin
      n_err++;
      $display("FAIL timeout early: valid got %b want 1", bus.NOTE_VALID);
    end
    @(negedge CLK_IN);
    model_clear(TIMEOUT);
    n_vec++;
    if (act_status() !== exp_status() || act_status() !== {1'b0, 3'd2, 17'd1500, 3'd0}) begin
      n_err++;
      $display("FAIL timeout drop: status got %h want %h", act_status(), exp_status());
    end
  endtask

  task automatic test_reset_midlock();
    for (int i = 0; i < 4; i++) tone_period(240, 240);
    n_vec++;
    if (act_status() !== exp_status() || bus.NOTE !== 3'd4) begin
      n_err++;
      $display("FAIL rst lock: status got %h want %h", act_status(), exp_status());
    end
    model_rise();
    m_len = 480;
    m_high = 240;
    bus.TONE_IN = 1'b1;
    repeat (240) @(negedge CLK_IN);
    bus.TONE_IN = 1'b0;
    repeat (100) @(negedge CLK_IN);
    RST_N = 1'b0;
    @(negedge CLK_IN);
    RST_N = 1'b1;
    model_clear(0);
    m_note = 0;
    n_vec++;
    if (act_status() !== 24'd0 || bus.NOTE_STROBE !== 1'b0) begin
      n_err++;
      $display("FAIL rst midlock: status got %h strobe %b want 0", act_status(), bus.NOTE_STROBE);
    end
    repeat (140) @(negedge CLK_IN);
    for (int i = 0; i < 4; i++) begin
      tone_period(240, 240);
      n_vec++;
      if (act_status() !== exp_status() || bus.NOTE_VALID !== (i == 3)) begin
        n_err++;
        $display("FAIL rst relock p%0d: status got %h want %h", i, act_status(), exp_status());
      end
    end
    n_vec++;
    if (strobe_seen !== m_strobes) begin
      n_err++;
      $display("FAIL rst strobes: got %0d want %0d", strobe_seen, m_strobes);
    end
  endtask

  task automatic test_random();
    int k, len, tol, p, h;
    for (int seg = 0; seg < 8; seg++) begin
      k = int'($urandom_range(0, 8));
      len = int'($urandom_range(1, 5));
      for (int j = 0; j < len; j++) begin
        if (k < 8) begin
          tol = np_tab[k] >> TOL_SHIFT;
          p = np_tab[k] - tol + int'($urandom_range(0, 2 * tol));
        end else begin
          p = int'($urandom_range(340, 760));
        end
        h = p / 2 - 1 + int'($urandom_range(0, 2));
`ifdef TONE_DUTY_CHECK_EN
        if ($urandom_range(0, 4) == 0) h = p / 4;
`endif
        tone_period(h, p - h);
        n_vec++;
        if (act_status() !== exp_status() || strobe_seen !== m_strobes) begin
          n_err++;
          $display("FAIL random s%0d p%0d P=%0d: status got %h want %h strobes %0d want %0d",
                   seg, j, p, act_status(), exp_status(), strobe_seen, m_strobes);
        end
      end
    end
  endtask

`ifdef TONE_DUTY_CHECK_EN
  task automatic test_duty();
    for (int i = 0; i < 6; i++) begin
      tone_period(179, 539);
      n_vec++;
      if (act_status() !== exp_status()) begin
        n_err++;
        $display("FAIL duty p%0d: status got %h want %h", i, act_status(), exp_status());
      end
    end
    n_vec++;
    if (bus.NOTE_VALID !== 1'b0 || strobe_seen !== m_strobes) begin
      n_err++;
      $display("FAIL duty final: valid %b want 0", bus.NOTE_VALID);
    end
  endtask
`endif

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) np_tab[i] = 2 * (CLK_HZ / FREQ[i] + 1);
    bus.TONE_IN = 1'b0;
    test_reset();
    test_lock_523();
    test_switch();
    test_tolerance();
    test_out_of_band();
    test_timeout();
    test_reset_midlock();
    test_random();
`ifdef TONE_DUTY_CHECK_EN
    test_duty();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
